// File: rtl/sdiv_arb_pkg.sv
// Shared definitions for the two-requester signed-divider arbiter: FSM states and default width.
package sdiv_arb_pkg;

    localparam int SDIV_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } sdiv_state_e;

endpackage

// File: rtl/sdiv_rr_pick.sv
// Two-way round-robin grant pick: a lone request wins outright, a tie goes to prio.
module sdiv_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic gnt,
    output logic owner
);

    assign gnt   = req0 | req1;
    assign owner = (req0 & req1) ? prio : req1;

endmodule

// File: rtl/sdiv_arb.sv
// Arbitrates two requesters onto one shared go/rdy signed divider and returns per-requester quotients.
// Optional macro SDIV_ARB_DIV0_CHK_EN short-circuits divide-by-zero to a saturated result with err set.
module sdiv_arb
    import sdiv_arb_pkg::*;
#(
    parameter int W = SDIV_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] dvd0,
    input  logic [W-1:0] dvs0,
    input  logic [W-1:0] dvd1,
    input  logic [W-1:0] dvs1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] quo0,
    output logic [W-1:0] quo1,
    output logic         err0,
    output logic         err1,
    output logic         div_go,
    output logic [W-1:0] div_dividend,
    output logic [W-1:0] div_divisor,
    input  logic         div_rdy,
    input  logic [W-1:0] div_quotient
);

    sdiv_state_e  state_q, state_d;
    logic         prio_q, prio_d;
    logic         owner_q, owner_d;
    logic [W-1:0] dvd_q, dvd_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic [W-1:0] quo0_q, quo0_d;
    logic [W-1:0] quo1_q, quo1_d;

    logic         gnt;
    logic         pick;
    logic [W-1:0] sel_dvd;
    logic [W-1:0] sel_dvs;

    sdiv_rr_pick u_pick (
        .req0  (req0),
        .req1  (req1),
        .prio  (prio_q),
        .gnt   (gnt),
        .owner (pick)
    );

    assign sel_dvd = pick ? dvd1 : dvd0;
    assign sel_dvs = pick ? dvs1 : dvs0;

`ifdef SDIV_ARB_DIV0_CHK_EN
    localparam logic [W-1:0] QUO_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] QUO_MIN = {1'b1, {(W-1){1'b0}}};
    logic err0_q, err0_d;
    logic err1_q, err1_d;
`endif

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo0_d  = quo0_q;
        quo1_d  = quo1_q;
`ifdef SDIV_ARB_DIV0_CHK_EN
        err0_d  = err0_q;
        err1_d  = err1_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt) begin
                    owner_d = pick;
                    dvd_d   = sel_dvd;
                    dvs_d   = sel_dvs;
                    state_d = ST_ISSUE;
`ifdef SDIV_ARB_DIV0_CHK_EN
                    // Zero divisor never reaches the divider; answer is saturated toward the dividend's sign.
                    if (sel_dvs == '0) begin
                        state_d = ST_DONE;
                        if (pick) begin
                            quo1_d = sel_dvd[W-1] ? QUO_MIN : QUO_MAX;
                            err1_d = 1'b1;
                        end else begin
                            quo0_d = sel_dvd[W-1] ? QUO_MIN : QUO_MAX;
                            err0_d = 1'b1;
                        end
                    end
`endif
                end
            end
            ST_ISSUE: state_d = ST_ARM;
            // The divider may still show rdy from its previous result here, so it is not sampled.
            ST_ARM:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (div_rdy) begin
                    if (owner_q) begin
                        quo1_d = div_quotient;
`ifdef SDIV_ARB_DIV0_CHK_EN
                        err1_d = 1'b0;
`endif
                    end else begin
                        quo0_d = div_quotient;
`ifdef SDIV_ARB_DIV0_CHK_EN
                        err0_d = 1'b0;
`endif
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                prio_d  = ~owner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo0_q  <= '0;
            quo1_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo0_q  <= quo0_d;
            quo1_q  <= quo1_d;
        end
    end

`ifdef SDIV_ARB_DIV0_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            err0_q <= err0_d;
            err1_q <= err1_d;
        end
    end

    assign err0 = err0_q;
    assign err1 = err1_q;
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    assign div_go       = (state_q == ST_ISSUE);
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign done0        = (state_q == ST_DONE) && !owner_q;
    assign done1        = (state_q == ST_DONE) &&  owner_q;
    assign quo0         = quo0_q;
    assign quo1         = quo1_q;

endmodule

// File: tb/tb_sdiv_arb.sv
// Self-checking bench for sdiv_arb: directed scenarios plus randomized traffic against a
// transaction-level arbitration/division model and a behavioural go/rdy divider.
module tb_sdiv_arb;

    localparam int W = 16;
    localparam logic [W-1:0] DIV0_Q = 16'hFFFF;  // what the modelled divider returns for x/0

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] dvd0, dvs0, dvd1, dvs1;
    logic         done0, done1, err0, err1;
    logic [W-1:0] quo0, quo1;
    logic         div_go;
    logic [W-1:0] div_dividend, div_divisor;
    logic         div_rdy;
    logic [W-1:0] div_quotient;

    sdiv_arb #(.W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .req1         (req1),
        .dvd0         (dvd0),
        .dvs0         (dvs0),
        .dvd1         (dvd1),
        .dvs1         (dvs1),
        .done0        (done0),
        .done1        (done1),
        .quo0         (quo0),
        .quo1         (quo1),
        .err0         (err0),
        .err1         (err1),
        .div_go       (div_go),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_rdy      (div_rdy),
        .div_quotient (div_quotient)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit           m_prio = 1'b0;
    logic [W-1:0] m_quo [2];

    function automatic logic [W-1:0] sdiv_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        int ai;
        int bi;
        ai = $signed(a);
        bi = $signed(b);
        if (bi == 0) return DIV0_Q;
        return W'(ai / bi);
    endfunction

    // Behavioural divider: rdy stays stale-high one cycle after go, then low for div_extra cycles.
    int           div_extra = 0;
    logic         div_stale = 1'b0;
    int           div_cnt   = 0;
    logic [W-1:0] div_q_r   = '0;

    always @(posedge clk) begin
        if (div_go === 1'b1) begin
            div_stale <= 1'b1;
            div_cnt   <= div_extra;
            div_q_r   <= sdiv_ref(div_dividend, div_divisor);
        end else begin
            div_stale <= 1'b0;
            if (!div_stale && div_cnt > 0) div_cnt <= div_cnt - 1;
        end
    end

    assign div_rdy      = div_stale || (div_cnt == 0);
    assign div_quotient = div_q_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/done0"}, {31'd0, done0}, 0);
        chk({tag, "/done1"}, {31'd0, done1}, 0);
        chk({tag, "/quo0"}, {16'd0, quo0}, 0);
        chk({tag, "/quo1"}, {16'd0, quo1}, 0);
        chk({tag, "/err0"}, {31'd0, err0}, 0);
        chk({tag, "/err1"}, {31'd0, err1}, 0);
        chk({tag, "/div_go"}, {31'd0, div_go}, 0);
        chk({tag, "/div_dividend"}, {16'd0, div_dividend}, 0);
        chk({tag, "/div_divisor"}, {16'd0, div_divisor}, 0);
    endtask

    function automatic logic [W-1:0] rand_dvd();
        logic [W-1:0] v;
        v = W'($urandom);
        if (v == 16'h8000) v = 16'h8001;
        return v;
    endfunction

    function automatic logic [W-1:0] rand_dvs();
        logic [W-1:0] v;
        if ($urandom_range(0, 7) == 0) return '0;
        v = W'($urandom);
        if (v == '0) v = 16'h0001;
        return v;
    endfunction

    // Called at a negedge in an IDLE cycle with requests already driven. Serves one transaction,
    // returns at the negedge of the following IDLE cycle.
    task automatic serve(input int extra, input bit mutate, input bit keep, input string tag,
                         output bit own);
        bit           d0path;
        bit           got;
        logic [W-1:0] e_dvd, e_dvs, e_quo, other_quo;
        int           cyc, go_cnt, go_cyc;
        own   = (req0 && req1) ? m_prio : req1;
        e_dvd = own ? dvd1 : dvd0;
        e_dvs = own ? dvs1 : dvs0;
`ifdef SDIV_ARB_DIV0_CHK_EN
        d0path = (e_dvs == '0);
`else
        d0path = 1'b0;
`endif
        e_quo     = d0path ? (e_dvd[W-1] ? 16'h8000 : 16'h7FFF) : sdiv_ref(e_dvd, e_dvs);
        other_quo = m_quo[!own];
        div_extra = extra;
        cyc = 0; go_cnt = 0; go_cyc = 0; got = 1'b0;
        while (cyc < 40 && !got) begin
            @(negedge clk);
            cyc++;
            if (div_go === 1'b1) begin
                go_cnt++;
                go_cyc = cyc;
                chk({tag, "/go_dividend"}, {16'd0, div_dividend}, {16'd0, e_dvd});
                chk({tag, "/go_divisor"}, {16'd0, div_divisor}, {16'd0, e_dvs});
                if (mutate) begin
                    if (own) dvd1 = dvd1 ^ 16'h5A5A;
                    else     dvd0 = dvd0 ^ 16'h5A5A;
                end
            end
            if (done0 === 1'b1 || done1 === 1'b1) got = 1'b1;
        end
        chk({tag, "/done_seen"}, {31'd0, got}, 1);
        chk({tag, "/done0"}, {31'd0, done0}, {31'd0, !own});
        chk({tag, "/done1"}, {31'd0, done1}, {31'd0, own});
        chk({tag, "/quo_owner"}, {16'd0, own ? quo1 : quo0}, {16'd0, e_quo});
        chk({tag, "/quo_other"}, {16'd0, own ? quo0 : quo1}, {16'd0, other_quo});
        chk({tag, "/err_owner"}, {31'd0, own ? err1 : err0}, {31'd0, d0path});
        chk({tag, "/go_count"}, go_cnt, d0path ? 0 : 1);
        if (!d0path) begin
            chk({tag, "/go_cycle"}, go_cyc, 1);
            chk({tag, "/done_cycle"}, cyc, 4 + extra);
        end
        $display("[TB] txn %s owner=%0d dvd=%0h dvs=%0h quo=%0h err=%0d cycles=%0d",
                 tag, own, e_dvd, e_dvs, own ? quo1 : quo0, own ? err1 : err0, cyc);
        m_quo[own] = e_quo;
        m_prio     = !own;
        if (!keep) begin
            if (own) req1 = 1'b0;
            else     req0 = 1'b0;
        end
        @(negedge clk);
        chk({tag, "/done_single"}, {30'd0, done0, done1}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_prio = 1'b0;
        m_quo[0] = '0;
        m_quo[1] = '0;
    endtask

    initial begin
        bit own;
        bit owners [4];
        bit saw_done;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        dvd0 = '0; dvs0 = '0; dvd1 = '0; dvs1 = '0;
        m_quo[0] = '0; m_quo[1] = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic 8/2 on requester 0
        req0 = 1'b1; dvd0 = 16'd8; dvs0 = 16'd2;
        serve(0, 1'b0, 1'b0, "basic", own);
        chk("basic/quo0_const", {16'd0, quo0}, 32'h0004);
        chk("basic/err0_const", {31'd0, err0}, 0);

        // Simultaneous requests after reset: requester 0 first, then 1
        do_reset();
        req0 = 1'b1; dvd0 = -16'sd100; dvs0 = 16'd7;
        req1 = 1'b1; dvd1 = 16'd50;    dvs1 = -16'sd5;
        serve(1, 1'b0, 1'b0, "tie_a", own);
        chk("tie_a/owner", {31'd0, own}, 0);
        serve(0, 1'b0, 1'b0, "tie_b", own);
        chk("tie_b/owner", {31'd0, own}, 1);
        chk("tie/quo0_const", {16'd0, quo0}, 32'hFFF2);
        chk("tie/quo1_const", {16'd0, quo1}, 32'hFFF6);

        // Both held: grants alternate starting with 0
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dvd0 = rand_dvd(); dvs0 = rand_dvs();
            dvd1 = rand_dvd(); dvs1 = rand_dvs();
            serve(i % 3, 1'b0, 1'b1, $sformatf("alt%0d", i), own);
            owners[i] = own;
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("alt%0d/owner", i), {31'd0, owners[i]}, i % 2);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // Divide by zero on requester 1
        req1 = 1'b1; dvd1 = -16'sd5; dvs1 = 16'd0;
        serve(0, 1'b0, 1'b0, "div0", own);
`ifdef SDIV_ARB_DIV0_CHK_EN
        chk("div0/quo1_const", {16'd0, quo1}, 32'h8000);
        chk("div0/err1_const", {31'd0, err1}, 1);
`else
        chk("div0/err1_const", {31'd0, err1}, 0);
`endif

        // Operand change after go must not leak into the result
        req0 = 1'b1; dvd0 = 16'd1000; dvs0 = 16'd10;
        serve(2, 1'b1, 1'b0, "mutate", own);
        chk("mutate/quo0_const", {16'd0, quo0}, 32'd100);

        // Reset during WAIT aborts; the late rdy must not produce a done
        req0 = 1'b1; dvd0 = 16'd9; dvs0 = 16'd3;
        div_extra = 10;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0; req0 = 1'b0;
        m_prio = 1'b0; m_quo[0] = '0; m_quo[1] = '0;
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done0 === 1'b1 || done1 === 1'b1 || div_go === 1'b1) saw_done = 1'b1;
        end
        chk("abort/no_late_done", {31'd0, saw_done}, 0);
        chk("abort/quo0_held", {16'd0, quo0}, 0);
        req0 = 1'b1; dvd0 = 16'd8; dvs0 = 16'd2;
        serve(0, 1'b0, 1'b0, "post_abort", own);
        chk("post_abort/quo0_const", {16'd0, quo0}, 32'h0004);

        // Randomized traffic; a pending non-owner keeps its request and operands
        for (int i = 0; i < 16; i++) begin
            if (!req0 && $urandom_range(0, 1) == 1) begin
                req0 = 1'b1; dvd0 = rand_dvd(); dvs0 = rand_dvs();
            end
            if (!req1 && $urandom_range(0, 1) == 1) begin
                req1 = 1'b1; dvd1 = rand_dvd(); dvs1 = rand_dvs();
            end
            if (!req0 && !req1) begin
                req0 = 1'b1; dvd0 = rand_dvd(); dvs0 = rand_dvs();
            end
            serve($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0,
                  $sformatf("rand%0d", i), own);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
